// File: rtl/falafel_fwft_fifo.sv
// falafel_fwft_fifo: first-word-fall-through FIFO with valid/ready on both sides.
// Storage is a wrapping array of NUM_ENTRIES-1 words feeding one registered
// output stage. The head word is always held in that stage.
// Optional macro FALAFEL_FWFT_BYPASS_EN: an empty FIFO forwards in_data_i to
// out_data_o combinationally, and passes the word straight through when the
// consumer is ready.
module falafel_fwft_fifo #(
   parameter int NUM_ENTRIES = 64,
   parameter int DATA_W      = 16,
   parameter int AF_THRESH   = NUM_ENTRIES - 4,
   parameter int AE_THRESH   = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             flush_i,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [DATA_W-1:0]                in_data_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [DATA_W-1:0]                out_data_o,
   output logic [$clog2(NUM_ENTRIES+1)-1:0] count_o,
   output logic                             almost_full_o,
   output logic                             almost_empty_o
);
   localparam int CW    = $clog2(NUM_ENTRIES + 1);
   localparam int DEPTH = NUM_ENTRIES - 1;
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_C = CW'(NUM_ENTRIES);
   localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
   localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] stage_q, stage_d;
   logic              ov_q, ov_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              af_q, ae_q;
   logic              push, pop_stage, passthru, push_st, wr_en, arr_empty;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_P) ? '0 : p + PW'(1);
   endfunction

   // The output stage is full whenever count is nonzero, so the array holds count-1.
   assign arr_empty  = (count_q < CW'(2));
   assign in_ready_o = (count_q < FULL_C);
   assign push       = in_valid_i & in_ready_o;
   assign pop_stage  = ov_q & out_ready_i;

`ifdef FALAFEL_FWFT_BYPASS_EN
   assign passthru    = ~ov_q & in_valid_i & out_ready_i;
   assign out_valid_o = ov_q | in_valid_i;
   assign out_data_o  = ov_q ? stage_q : in_data_i;
`else
   assign passthru    = 1'b0;
   assign out_valid_o = ov_q;
   assign out_data_o  = stage_q;
`endif

   // A passed-through word is never stored.
   assign push_st = push & ~passthru;

   assign count_o        = count_q;
   assign almost_full_o  = af_q;
   assign almost_empty_o = ae_q;

   // Next-state: refill the output stage from the array head, else from the input.
   always_comb begin
      stage_d  = stage_q;
      ov_d     = ov_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      wr_en    = 1'b0;
      if (pop_stage || !ov_q) begin
         if (!arr_empty) begin
            stage_d  = mem_q[rd_ptr_q];
            ov_d     = 1'b1;
            rd_ptr_d = ptr_inc(rd_ptr_q);
            wr_en    = push_st;
         end else if (push_st) begin
            stage_d = in_data_i;
            ov_d    = 1'b1;
         end else begin
            ov_d = 1'b0;
         end
      end else begin
         wr_en = push_st;
      end
      if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(push_st) - CW'(pop_stage);
      if (flush_i) begin
         count_d  = '0;
         ov_d     = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         wr_en    = 1'b0;
      end
   end

   // Array write port; contents need no reset because pointers do.
   always_ff @(posedge clk_i) begin
      if (wr_en && !rst_i) mem_q[wr_ptr_q] <= in_data_i;
   end

   // Control state and registered flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_q  <= '0;
         ov_q     <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
      end else begin
         stage_q  <= stage_d;
         ov_q     <= ov_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         af_q     <= (count_d >= AF_C);
         ae_q     <= (count_d <= AE_C);
      end
   end
endmodule

// File: tb/tb_falafel_fwft_fifo.sv
// Directed bench for falafel_fwft_fifo (NUM_ENTRIES=64, DATA_W=16, AF=60, AE=4).
module tb_falafel_fwft_fifo;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid, af, ae;
   logic [15:0] in_data, out_data;
   logic [6:0]  count;
   int          errors = 0;
   int          checks = 0;

   falafel_fwft_fifo #(.NUM_ENTRIES(64), .DATA_W(16)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .count_o(count), .almost_full_o(af), .almost_empty_o(ae)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
      step(); step();
      rst = 0;
      step();
      // 1. reset / idle state
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_ae", 32'(ae), 1);
      chk("rst_af", 32'(af), 0);

      // 2. fill with 1..64, consumer stalled
      for (int i = 1; i <= 64; i++) begin
         in_valid = 1; in_data = 16'(i);
         step();
         chk("fill_count", 32'(count), 32'(i));
         chk("fill_af", 32'(af), (i >= 60) ? 1 : 0);
         chk("fill_ae", 32'(ae), (i <= 4) ? 1 : 0);
         chk("fill_in_ready", 32'(in_ready), (i < 64) ? 1 : 0);
         chk("fill_head_stable", 32'(out_data), 1);
         chk("fill_out_valid", 32'(out_valid), 1);
      end
      in_data = 16'hFFFF;
      step();
      chk("full_refuse_count", 32'(count), 64);
      in_valid = 0; out_ready = 1;
      for (int i = 1; i <= 64; i++) begin
         chk("drain_valid", 32'(out_valid), 1);
         chk("drain_data", 32'(out_data), 32'(i));
         step();
      end
      out_ready = 0;
      chk("drain_count", 32'(count), 0);
      chk("drain_out_valid", 32'(out_valid), 0);
      chk("drain_ae", 32'(ae), 1);

      // 3. streaming, both sides always ready
      in_valid = 1; out_ready = 1; in_data = 16'h0100;
      step();
      for (int k = 1; k < 200; k++) begin
         in_data = 16'(16'h0100 + k);
         chk("stream_valid", 32'(out_valid), 1);
         chk("stream_data", 32'(out_data), 32'(16'h0100 + k - 1));
         chk("stream_count", 32'(count), 1);
         step();
      end
      in_valid = 0;
      chk("stream_last", 32'(out_data), 32'h0000_01C7);
      step();
      out_ready = 0;
      chk("stream_end_count", 32'(count), 0);

      // 4. full FIFO with push and pop together
      for (int i = 0; i < 64; i++) begin
         in_valid = 1; in_data = 16'(16'h0200 + i);
         step();
      end
      chk("full2_count", 32'(count), 64);
      chk("full2_in_ready", 32'(in_ready), 0);
      in_data = 16'hDEAD; out_ready = 1;
      step();
      in_valid = 0;
      chk("pp_count", 32'(count), 63);
      chk("pp_in_ready", 32'(in_ready), 1);
      chk("pp_af", 32'(af), 1);
      for (int i = 1; i < 64; i++) begin
         chk("pp_drain_data", 32'(out_data), 32'(16'h0200 + i));
         step();
      end
      out_ready = 0;
      chk("pp_drain_count", 32'(count), 0);
      chk("pp_drain_valid", 32'(out_valid), 0);

      // 5. flush with concurrent push and pop at count 10
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; in_data = 16'(16'h0300 + i);
         step();
      end
      chk("pre_flush_count", 32'(count), 10);
      flush = 1; in_valid = 1; in_data = 16'h5555; out_ready = 1;
      step();
      flush = 0; in_valid = 0; out_ready = 0;
      chk("flush_count", 32'(count), 0);
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_ae", 32'(ae), 1);
      in_valid = 1; in_data = 16'hBEEF;
      step();
      in_valid = 0;
      chk("post_flush_valid", 32'(out_valid), 1);
      chk("post_flush_data", 32'(out_data), 32'h0000_BEEF);
      chk("post_flush_count", 32'(count), 1);
      out_ready = 1;
      step();
      out_ready = 0;
      chk("post_flush_empty", 32'(count), 0);

      // 6. latency from an empty FIFO with consumer ready
      in_valid = 1; out_ready = 1; in_data = 16'h1234;
      #1;
`ifdef FALAFEL_FWFT_BYPASS_EN
      chk("byp_same_valid", 32'(out_valid), 1);
      chk("byp_same_data", 32'(out_data), 32'h0000_1234);
      step();
      in_valid = 0;
      chk("byp_count", 32'(count), 0);
      chk("byp_after_valid", 32'(out_valid), 0);
`else
      chk("lat_same_valid", 32'(out_valid), 0);
      step();
      in_valid = 0;
      chk("lat_next_valid", 32'(out_valid), 1);
      chk("lat_next_data", 32'(out_data), 32'h0000_1234);
      chk("lat_next_count", 32'(count), 1);
      step();
      chk("lat_popped_count", 32'(count), 0);
`endif
      out_ready = 0;

      // reset mid-stream discards contents
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = 16'(16'h0400 + i);
         step();
      end
      chk("pre_rst_count", 32'(count), 3);
      rst = 1; flush = 1; in_valid = 0;
      step();
      rst = 0; flush = 0;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_data", 32'(out_data), 0);
      chk("midrst_ae", 32'(ae), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
